// File: rtl/clock_result_checker_if.sv
// Bundle between the reference/fabric compare point and the result checker.
// The stimulus side is the master; the checker is the slave.
interface clock_result_checker_if #(
  parameter int DATA_OUT_WIRE_WIDTH = 48,
  parameter int CNT_WIDTH           = 16
);
  logic [DATA_OUT_WIRE_WIDTH-1:0] data_out;
  logic [DATA_OUT_WIRE_WIDTH-1:0] expected_dataout;
  logic [DATA_OUT_WIRE_WIDTH-1:0] ignore_mask;
  logic                           clock_finished;
  logic                           clock_result;
  logic                           result_valid;
  logic [CNT_WIDTH-1:0]           mismatch_count;
  logic [CNT_WIDTH-1:0]           compare_count;
  logic [CNT_WIDTH-1:0]           first_fail_cycle;
  logic [DATA_OUT_WIRE_WIDTH-1:0] first_fail_vector;
  logic [CNT_WIDTH-1:0]           trial_count;

  modport master (
    output data_out, expected_dataout, ignore_mask, clock_finished,
    input  clock_result, result_valid, mismatch_count, compare_count,
           first_fail_cycle, first_fail_vector, trial_count
  );

  modport slave (
    input  data_out, expected_dataout, ignore_mask, clock_finished,
    output clock_result, result_valid, mismatch_count, compare_count,
           first_fail_cycle, first_fail_vector, trial_count
  );
endinterface

// File: rtl/clock_result_checker.sv
// Per-cycle fabric vs. golden output comparison with a pass/fail verdict per
// max-clock trial, delimited by the clock_finished level from the stimulus side.
module clock_result_checker #(
  parameter int DATA_OUT_WIRE_WIDTH = 48,
  parameter int WARMUP_CYCLES       = 2,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                   clk,
  input  logic                   sys_reset,
  clock_result_checker_if.slave  bus
);

  localparam int WC_W = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WARMUP, COMPARE, REPORT} state_t;

  state_t                         state_q, state_d;
  logic                           cf_q;
  logic [WC_W-1:0]                wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0]           mismatch_q, mismatch_d;
  logic [CNT_WIDTH-1:0]           compare_q, compare_d;
  logic [CNT_WIDTH-1:0]           ffc_q, ffc_d;
  logic [DATA_OUT_WIRE_WIDTH-1:0] ffv_q, ffv_d;
  logic [CNT_WIDTH-1:0]           trial_q, trial_d;
  logic                           result_q, result_d;
  logic                           valid_q, valid_d;

  logic                           rise, fall, miss;
  logic [DATA_OUT_WIRE_WIDTH-1:0] miss_vec;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign rise     = bus.clock_finished & ~cf_q;
  assign fall     = ~bus.clock_finished & cf_q;
  assign miss_vec = (bus.data_out ^ bus.expected_dataout) & ~bus.ignore_mask;
  assign miss     = |miss_vec;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    mismatch_d = mismatch_q;
    compare_d  = compare_q;
    ffc_d      = ffc_q;
    ffv_d      = ffv_q;
    trial_d    = trial_q;
    result_d   = result_q;
    valid_d    = valid_q;

    // The cycle that enters WARMUP is itself the first warmup cycle.
    case (state_q)
      IDLE, REPORT: begin
        if ((state_q == IDLE && !bus.clock_finished) || (state_q == REPORT && fall)) begin
          state_d    = WARMUP;
          wcnt_d     = WC_W'(1);
          mismatch_d = '0;
          compare_d  = '0;
          ffc_d      = '0;
          ffv_d      = '0;
          result_d   = 1'b0;
          valid_d    = 1'b0;
        end
      end
      WARMUP, COMPARE: begin
        if (rise) begin
          state_d  = REPORT;
          result_d = (mismatch_q == '0);
          valid_d  = 1'b1;
          trial_d  = sat_inc(trial_q);
        end else if (state_q == WARMUP) begin
          if (WARMUP_CYCLES <= 1 || int'(wcnt_q) >= WARMUP_CYCLES - 1) begin
            state_d = COMPARE;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end else begin
          compare_d = sat_inc(compare_q);
          if (miss) begin
            mismatch_d = sat_inc(mismatch_q);
            if (mismatch_q == '0) begin
              ffc_d = compare_q;
              ffv_d = miss_vec;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q    <= IDLE;
      cf_q       <= 1'b0;
      wcnt_q     <= '0;
      mismatch_q <= '0;
      compare_q  <= '0;
      ffc_q      <= '0;
      ffv_q      <= '0;
      trial_q    <= '0;
      result_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cf_q       <= bus.clock_finished;
      wcnt_q     <= wcnt_d;
      mismatch_q <= mismatch_d;
      compare_q  <= compare_d;
      ffc_q      <= ffc_d;
      ffv_q      <= ffv_d;
      trial_q    <= trial_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.clock_result      = result_q & valid_q;
  assign bus.result_valid      = valid_q;
  assign bus.mismatch_count    = mismatch_q;
  assign bus.compare_count     = compare_q;
  assign bus.first_fail_cycle  = ffc_q;
  assign bus.first_fail_vector = ffv_q;
  assign bus.trial_count       = trial_q;

endmodule

// File: tb/tb_clock_result_checker.sv
// Bench for clock_result_checker: a 16-bit-counter and a 4-bit-counter instance
// see identical stimulus and are checked against a trial-level reference model.
module tb_clock_result_checker;

  localparam int W  = 2;
  localparam int DW = 48;

  logic clk = 1'b0;
  logic sys_reset;
  int   errs   = 0;
  int   checks = 0;
  int   tcnt   = 0;
  int   maxv[2] = '{65535, 15};

  always #5 clk = ~clk;

  clock_result_checker_if #(.DATA_OUT_WIRE_WIDTH(DW), .CNT_WIDTH(16)) bus16 ();
  clock_result_checker_if #(.DATA_OUT_WIRE_WIDTH(DW), .CNT_WIDTH(4))  bus4 ();

  clock_result_checker #(.DATA_OUT_WIRE_WIDTH(DW), .WARMUP_CYCLES(W), .CNT_WIDTH(16)) dut16 (
    .clk(clk), .sys_reset(sys_reset), .bus(bus16.slave));
  clock_result_checker #(.DATA_OUT_WIRE_WIDTH(DW), .WARMUP_CYCLES(W), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .sys_reset(sys_reset), .bus(bus4.slave));

  typedef struct {
    logic          cr, rv;
    logic [15:0]   mc, cc, ffc, tc;
    logic [DW-1:0] ffv;
  } snap_t;

  function automatic snap_t snap_of(input int k);
    snap_t s;
    if (k == 0) begin
      s.cr = bus16.clock_result;  s.rv = bus16.result_valid;
      s.mc = bus16.mismatch_count; s.cc = bus16.compare_count;
      s.ffc = bus16.first_fail_cycle; s.tc = bus16.trial_count;
      s.ffv = bus16.first_fail_vector;
    end else begin
      s.cr = bus4.clock_result;  s.rv = bus4.result_valid;
      s.mc = 16'(bus4.mismatch_count); s.cc = 16'(bus4.compare_count);
      s.ffc = 16'(bus4.first_fail_cycle); s.tc = 16'(bus4.trial_count);
      s.ffv = bus4.first_fail_vector;
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] rnd_nz();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0] | (48'd1 << $urandom_range(0, DW-1));
  endfunction

  function automatic logic [DW-1:0] gen_err(input int mode, input int i);
    case (mode)
      1:       return (i == W + 10 || i == W + 20) ? 48'h2000 : 48'h0;
      2:       return 48'h2000;
      3:       return (i < W) ? rnd_nz() : 48'h0;
      4:       return ($urandom_range(0, 3) == 0) ? rnd_nz() : 48'h0;
      5:       return rnd_nz();
      default: return 48'h0;
    endcase
  endfunction

  task automatic drive(input logic cf, input logic [DW-1:0] err, input logic [DW-1:0] mask);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    bus16.clock_finished = cf;  bus4.clock_finished = cf;
    bus16.data_out = r[DW-1:0]; bus4.data_out = r[DW-1:0];
    bus16.expected_dataout = r[DW-1:0] ^ err; bus4.expected_dataout = r[DW-1:0] ^ err;
    bus16.ignore_mask = mask;   bus4.ignore_mask = mask;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v, input int k);
    return (v > maxv[k]) ? maxv[k] : v;
  endfunction

  // One trial: n cycles with clock_finished low, a rise, then hold cycles high.
  task automatic run_trial(input string nm, input int n, input int mode,
                           input logic [DW-1:0] mask, input int hold);
    int mm[2], cc[2], ffc[2];
    logic [DW-1:0] ffv[2], eff;
    snap_t s;
    for (int k = 0; k < 2; k++) begin mm[k] = 0; cc[k] = 0; ffc[k] = 0; ffv[k] = '0; end
    for (int i = 0; i < n; i++) begin
      eff = gen_err(mode, i);
      drive(1'b0, eff, mask);
      eff = eff & ~mask;
      tick();
      if (i >= W) begin
        for (int k = 0; k < 2; k++) begin
          if (eff != '0) begin
            if (mm[k] == 0) begin ffc[k] = cc[k]; ffv[k] = eff; end
            mm[k] = sat(mm[k] + 1, k);
          end
          cc[k] = sat(cc[k] + 1, k);
        end
      end
      if (i == 0 || i == n - 1) begin
        for (int k = 0; k < 2; k++) begin
          s = snap_of(k);
          checks++; if (s.rv !== 1'b0) begin errs++; $display("FAIL %s dut%0d valid_in_trial: got %0b want 0", nm, k, s.rv); end
          checks++; if (s.cr !== 1'b0) begin errs++; $display("FAIL %s dut%0d result_in_trial: got %0b want 0", nm, k, s.cr); end
          checks++; if (s.mc !== 16'(mm[k])) begin errs++; $display("FAIL %s dut%0d running_mismatch: got %0d want %0d", nm, k, s.mc, mm[k]); end
          checks++; if (s.cc !== 16'(cc[k])) begin errs++; $display("FAIL %s dut%0d running_compare: got %0d want %0d", nm, k, s.cc, cc[k]); end
          checks++; if (s.tc !== 16'(sat(tcnt, k))) begin errs++; $display("FAIL %s dut%0d trial_in_trial: got %0d want %0d", nm, k, s.tc, sat(tcnt, k)); end
          if (i == 0) begin
            checks++; if (s.ffv !== '0 || s.ffc !== 16'd0) begin errs++; $display("FAIL %s dut%0d first_fail_cleared: got %0d/%0h want 0/0", nm, k, s.ffc, s.ffv); end
          end
        end
      end
    end
    // The comparison on the rise cycle must not be counted.
    drive(1'b1, rnd_nz(), 48'h0);
    tick();
    tcnt++;
    for (int k = 0; k < 2; k++) begin
      s = snap_of(k);
      checks++; if (s.rv !== 1'b1) begin errs++; $display("FAIL %s dut%0d result_valid: got %0b want 1", nm, k, s.rv); end
      checks++; if (s.cr !== (mm[k] == 0)) begin errs++; $display("FAIL %s dut%0d clock_result: got %0b want %0b", nm, k, s.cr, mm[k] == 0); end
      checks++; if (s.mc !== 16'(mm[k])) begin errs++; $display("FAIL %s dut%0d mismatch_count: got %0d want %0d", nm, k, s.mc, mm[k]); end
      checks++; if (s.cc !== 16'(cc[k])) begin errs++; $display("FAIL %s dut%0d compare_count: got %0d want %0d", nm, k, s.cc, cc[k]); end
      checks++; if (s.ffc !== 16'(ffc[k])) begin errs++; $display("FAIL %s dut%0d first_fail_cycle: got %0d want %0d", nm, k, s.ffc, ffc[k]); end
      checks++; if (s.ffv !== ffv[k]) begin errs++; $display("FAIL %s dut%0d first_fail_vector: got %0h want %0h", nm, k, s.ffv, ffv[k]); end
      checks++; if (s.tc !== 16'(sat(tcnt, k))) begin errs++; $display("FAIL %s dut%0d trial_count: got %0d want %0d", nm, k, s.tc, sat(tcnt, k)); end
    end
    for (int h = 0; h < hold; h++) begin
      drive(1'b1, rnd_nz(), 48'h0);
      tick();
      for (int k = 0; k < 2; k++) begin
        s = snap_of(k);
        checks++;
        if (s.rv !== 1'b1 || s.mc !== 16'(mm[k]) || s.cr !== (mm[k] == 0)) begin
          errs++; $display("FAIL %s dut%0d report_hold: got v%0b r%0b m%0d want v1 r%0b m%0d", nm, k, s.rv, s.cr, s.mc, mm[k] == 0, mm[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    snap_t s;
    sys_reset = 1'b1;
    drive(1'b1, 48'h0, 48'h0);
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      s = snap_of(k);
      checks++;
      if ({s.cr, s.rv} !== 2'b00 || s.mc !== 0 || s.cc !== 0 || s.ffc !== 0 || s.ffv !== '0 || s.tc !== 0) begin
        errs++; $display("FAIL reset dut%0d: got r%0b v%0b m%0d c%0d f%0d t%0d want all 0", k, s.cr, s.rv, s.mc, s.cc, s.ffc, s.tc);
      end
    end
    sys_reset = 1'b0;
    tcnt = 0;
    // A high clock_finished seen in IDLE must not produce a verdict.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rnd_nz(), 48'h0);
      tick();
      for (int k = 0; k < 2; k++) begin
        s = snap_of(k);
        checks++;
        if (s.rv !== 1'b0 || s.tc !== 0) begin
          errs++; $display("FAIL idle_rise dut%0d: got v%0b t%0d want v0 t0", k, s.rv, s.tc);
        end
      end
    end
  endtask

  task automatic test_pass();         run_trial("pass500", 500, 0, 48'h0, 2);    endtask
  task automatic test_bit13();        run_trial("bit13", 60, 1, 48'h0, 2);       endtask
  task automatic test_masked();       run_trial("masked", 40, 2, 48'h2000, 2);   endtask
  task automatic test_warmup_only();  run_trial("warmup", 30, 3, 48'h0, 1);      endtask
  task automatic test_saturation();   run_trial("saturate", 40, 5, 48'h0, 1);    endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    run_trial("rise_in_warmup", 1, 5, 48'h0, 0);
    for (int t = 0; t < 6; t++) begin
      r = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      run_trial("random", $urandom_range(3, 80), 4, r[DW-1:0], $urandom_range(0, 2));
    end
  endtask

  task automatic test_mid_reset();
    snap_t s;
    for (int i = 0; i < W + 5; i++) begin
      drive(1'b0, (i < W) ? 48'h0 : rnd_nz(), 48'h0);
      tick();
    end
    s = snap_of(0);
    checks++; if (s.mc !== 16'd5) begin errs++; $display("FAIL midreset_pre mismatch: got %0d want 5", s.mc); end
    sys_reset = 1'b1;
    drive(1'b0, 48'h0, 48'h0);
    tick();
    sys_reset = 1'b0;
    tcnt = 0;
    for (int k = 0; k < 2; k++) begin
      s = snap_of(k);
      checks++;
      if ({s.cr, s.rv} !== 2'b00 || s.mc !== 0 || s.cc !== 0 || s.ffc !== 0 || s.ffv !== '0 || s.tc !== 0) begin
        errs++; $display("FAIL midreset dut%0d: got r%0b v%0b m%0d c%0d f%0d t%0d want all 0", k, s.cr, s.rv, s.mc, s.cc, s.ffc, s.tc);
      end
    end
    run_trial("after_reset", 20, 4, 48'h0, 1);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_bit13();
    test_masked();
    test_warmup_only();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
